// File: rtl/util_display_pkg.sv
// Shared definitions for the MDP result display: FSM states, policy and
// world codes, glyph selectors with their active-low segment patterns
// (gfedcba), and the hex-to-segment table.
package util_display_pkg;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_SHOW  = 2'd1,
    ST_STALE = 2'd2
  } state_e;

  localparam logic [1:0] POL_UP    = 2'b00;
  localparam logic [1:0] POL_RIGHT = 2'b01;
  localparam logic [1:0] POL_DOWN  = 2'b10;
  localparam logic [1:0] POL_LEFT  = 2'b11;

  localparam logic [1:0] WORLD_FREE = 2'b00;
  localparam logic [1:0] WORLD_POS  = 2'b01;
  localparam logic [1:0] WORLD_NEG  = 2'b10;
  localparam logic [1:0] WORLD_WALL = 2'b11;

  typedef enum logic [2:0] {
    GLY_BLANK, GLY_DASH, GLY_P, GLY_N, GLY_UP, GLY_RIGHT, GLY_DOWN, GLY_LEFT
  } glyph_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_N     = 7'h2B;
  localparam logic [6:0] SEG_UP    = 7'h7E;
  localparam logic [6:0] SEG_RIGHT = 7'h79;
  localparam logic [6:0] SEG_DOWN  = 7'h77;
  localparam logic [6:0] SEG_LEFT  = 7'h4F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Active-low 7-segment encoder: either a hex nibble or a symbolic glyph.
module seg7_glyph
  import util_display_pkg::*;
(
  input  logic       use_hex_i,
  input  logic [3:0] nibble_i,
  input  glyph_e     glyph_i,
  output logic [6:0] seg_o
);

  // Pick the hex pattern or the glyph pattern for the active digit.
  always_comb begin
    seg_o = SEG_BLANK;
    if (use_hex_i) begin
      seg_o = hex_to_seg(nibble_i);
    end else begin
      case (glyph_i)
        GLY_DASH:  seg_o = SEG_DASH;
        GLY_P:     seg_o = SEG_P;
        GLY_N:     seg_o = SEG_N;
        GLY_UP:    seg_o = SEG_UP;
        GLY_RIGHT: seg_o = SEG_RIGHT;
        GLY_DOWN:  seg_o = SEG_DOWN;
        GLY_LEFT:  seg_o = SEG_LEFT;
        default:   seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/util_display.sv
// MDP result display: snapshots utility digits, policy and world map on the
// rising edge of Done and shows one cell at a time on a 4-digit multiplexed
// 7-segment display (AN3 cell index, AN2 type/policy, AN1.AN0 utility).
// Optional auto-scroll in SHOW: define UTIL_DISPLAY_AUTOSCROLL_EN.
module util_display
  import util_display_pkg::*;
#(
  parameter int NUM_CELLS    = 12,
  parameter int REFRESH_BITS = 18,
  parameter int AUTO_BITS    = 27
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Done,
  input  logic [47:0] Converted_1,
  input  logic [47:0] Converted_2,
  input  logic [63:0] Policy,
  input  logic [65:0] world,
  input  logic        Next,
  input  logic        Prev,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  cell_idx
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_CELLS - 1);

  state_e                  state_q, state_d;
  logic                    done_q;
  logic                    rise, fall;
  logic [3:0]              cell_idx_q, cell_idx_d;
  logic [REFRESH_BITS-1:0] refresh_q;
  logic [1:0]              sel;
  logic                    auto_tick;
  logic                    step_next, step_prev;

  logic [3:0] c1_in [NUM_CELLS];
  logic [3:0] c2_in [NUM_CELLS];
  logic [3:0] c1_q  [NUM_CELLS];
  logic [3:0] c2_q  [NUM_CELLS];
  logic [1:0] pol_q [NUM_CELLS];
  logic [1:0] wld_q [NUM_CELLS];

  logic       use_hex;
  logic [3:0] nibble;
  glyph_e     glyph;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;
  logic [3:0] an_q;
  logic [6:0] seg_q;
  logic       dp_q;

  // Only the low cells of Policy/world are browsable; the rest is ignored.
  logic unused_inputs;
  assign unused_inputs = ^{Policy, world, Converted_1, Converted_2};

  assign rise = Done & ~done_q;
  assign fall = ~Done & done_q;
  assign sel  = refresh_q[REFRESH_BITS-1 -: 2];

  // Done history for edge detection, plus the free-running refresh counter.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      done_q    <= 1'b0;
      refresh_q <= '0;
    end else begin
      done_q    <= Done;
      refresh_q <= refresh_q + 1'b1;
    end
  end

  // Per-cell snapshot, loaded only on a Done rise; digit inputs beyond the
  // 48-bit buses read as zero.
  for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
    if (gi < 12) begin : g_in
      assign c1_in[gi] = Converted_1[4*gi +: 4];
      assign c2_in[gi] = Converted_2[4*gi +: 4];
    end else begin : g_zero
      assign c1_in[gi] = 4'h0;
      assign c2_in[gi] = 4'h0;
    end

    // Hold the captured cell until the next run completes.
    always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
        c1_q[gi]  <= 4'h0;
        c2_q[gi]  <= 4'h0;
        pol_q[gi] <= 2'b00;
        wld_q[gi] <= 2'b00;
      end else if (rise) begin
        c1_q[gi]  <= c1_in[gi];
        c2_q[gi]  <= c2_in[gi];
        pol_q[gi] <= Policy[2*gi +: 2];
        wld_q[gi] <= world[2*gi +: 2];
      end
    end
  end

`ifdef UTIL_DISPLAY_AUTOSCROLL_EN
  logic [AUTO_BITS-1:0] auto_q;
  assign auto_tick = (state_q == ST_SHOW) && (auto_q == '1);

  // Auto-scroll timer: runs only in SHOW, restarted by any user activity.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      auto_q <= '0;
    end else if (rise || Next || Prev || state_q != ST_SHOW) begin
      auto_q <= '0;
    end else begin
      auto_q <= auto_q + 1'b1;
    end
  end
`else
  logic [AUTO_BITS-1:0] unused_auto;
  assign unused_auto = '0;
  assign auto_tick   = 1'b0;
`endif

  // Manual pulses take priority over the auto-scroll tick; both pressed cancel.
  assign step_next = (Next & ~Prev) | (auto_tick & ~Next & ~Prev);
  assign step_prev = Prev & ~Next;

  // State and cell index registers.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_BLANK;
      cell_idx_q <= 4'h0;
    end else begin
      state_q    <= state_d;
      cell_idx_q <= cell_idx_d;
    end
  end

  // Next-state and index logic; a Done rise always restarts at cell 0.
  always_comb begin
    state_d    = state_q;
    cell_idx_d = cell_idx_q;
    case (state_q)
      ST_BLANK: if (rise) state_d = ST_SHOW;
      ST_SHOW:  if (fall) state_d = ST_STALE;
      ST_STALE: if (rise) state_d = ST_SHOW;
      default:  state_d = ST_BLANK;
    endcase
    if (rise) begin
      cell_idx_d = 4'h0;
    end else if (state_q != ST_BLANK) begin
      if (step_next) begin
        cell_idx_d = (cell_idx_q == LAST_IDX) ? 4'h0 : cell_idx_q + 4'd1;
      end else if (step_prev) begin
        cell_idx_d = (cell_idx_q == 4'h0) ? LAST_IDX : cell_idx_q - 4'd1;
      end
    end
  end

  // Content of the digit selected by the refresh counter.
  always_comb begin
    an_d    = ~(4'b0001 << sel);
    dp_d    = 1'b1;
    use_hex = 1'b0;
    nibble  = 4'h0;
    glyph   = GLY_DASH;
    if (state_q != ST_BLANK) begin
      case (sel)
        2'd0: begin
          use_hex = 1'b1;
          nibble  = c2_q[cell_idx_q];
        end
        2'd1: begin
          use_hex = 1'b1;
          nibble  = c1_q[cell_idx_q];
          dp_d    = 1'b0;
        end
        2'd2: begin
          case (wld_q[cell_idx_q])
            WORLD_POS:  glyph = GLY_P;
            WORLD_NEG:  glyph = GLY_N;
            WORLD_WALL: glyph = GLY_DASH;
            default: begin
              case (pol_q[cell_idx_q])
                POL_UP:    glyph = GLY_UP;
                POL_RIGHT: glyph = GLY_RIGHT;
                POL_DOWN:  glyph = GLY_DOWN;
                default:   glyph = GLY_LEFT;
              endcase
            end
          endcase
        end
        default: begin
          use_hex = 1'b1;
          nibble  = cell_idx_q;
          dp_d    = (state_q == ST_STALE) ? 1'b0 : 1'b1;
        end
      endcase
    end
  end

  seg7_glyph u_glyph (
    .use_hex_i (use_hex),
    .nibble_i  (nibble),
    .glyph_i   (glyph),
    .seg_o     (seg_d)
  );

  // Anode, segments and dp change together so no digit shows another's data.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign cell_idx = cell_idx_q;

endmodule

// File: tb/tb_util_display.sv
// Directed bench for util_display with a small refresh counter so every
// digit is visited quickly; expected digit triples are queued per check.
module tb_util_display;

  logic        clk = 1'b0;
  logic        Reset, Done, Next, Prev;
  logic [47:0] Converted_1, Converted_2;
  logic [63:0] Policy;
  logic [65:0] world;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  cell_idx;

  util_display #(.NUM_CELLS(12), .REFRESH_BITS(4), .AUTO_BITS(27)) dut (
    .clk(clk), .Reset(Reset), .Done(Done),
    .Converted_1(Converted_1), .Converted_2(Converted_2),
    .Policy(Policy), .world(world), .Next(Next), .Prev(Prev),
    .an(an), .seg(seg), .dp(dp), .cell_idx(cell_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  logic [3:0] c1[12], c2[12], s_c1[12], s_c2[12];
  logic [1:0] pol[12], wld[12], s_pol[12], s_wld[12];

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [6:0] glyph7(input logic [1:0] w, input logic [1:0] p);
    case (w)
      2'b01: return 7'h0C;
      2'b10: return 7'h2B;
      2'b11: return 7'h3F;
      default: begin
        case (p)
          2'b00: return 7'h7E;
          2'b01: return 7'h79;
          2'b10: return 7'h77;
          default: return 7'h4F;
        endcase
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_cells();
    for (int k = 0; k < 12; k++) begin
      c1[k]  = 4'($urandom_range(0, 15));
      c2[k]  = 4'($urandom_range(0, 15));
      pol[k] = 2'($urandom_range(0, 3));
      wld[k] = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic drive_inputs();
    Policy = '0;
    world  = '0;
    for (int k = 0; k < 12; k++) begin
      Converted_1[4*k +: 4] = c1[k];
      Converted_2[4*k +: 4] = c2[k];
      Policy[2*k +: 2]      = pol[k];
      world[2*k +: 2]       = wld[k];
    end
  endtask

  task automatic take_snapshot();
    for (int k = 0; k < 12; k++) begin
      s_c1[k] = c1[k]; s_c2[k] = c2[k]; s_pol[k] = pol[k]; s_wld[k] = wld[k];
    end
  endtask

  task automatic push_entry(input logic [3:0] a, input logic [6:0] s, input logic d);
    exp_t e;
    e.an = a; e.seg = s; e.dp = d;
    sb.push_back(e);
  endtask

  // Expected digits in AN0..AN3 order for cell k.
  task automatic push_cell(input int k, input bit stale);
    push_entry(4'b1110, hex7(s_c2[k]), 1'b1);
    push_entry(4'b1101, hex7(s_c1[k]), 1'b0);
    push_entry(4'b1011, glyph7(s_wld[k], s_pol[k]), 1'b1);
    push_entry(4'b0111, hex7(4'(k)), stale ? 1'b0 : 1'b1);
  endtask

  task automatic push_blank();
    push_entry(4'b1110, 7'h3F, 1'b1);
    push_entry(4'b1101, 7'h3F, 1'b1);
    push_entry(4'b1011, 7'h3F, 1'b1);
    push_entry(4'b0111, 7'h3F, 1'b1);
  endtask

  // Align to the start of an AN0 window, then compare one sample per digit.
  task automatic check_display(input string tag);
    int n;
    exp_t e;
    n = 0;
    while (an == 4'b1110 && n < 40) begin @(negedge clk); n++; end
    n = 0;
    while (an != 4'b1110 && n < 40) begin @(negedge clk); n++; end
    checks++;
    assert (an == 4'b1110) else begin
      failures++;
      $error("FAIL %s_sync observed an=%b expected an=1110", tag, an);
      sb.delete();
      return;
    end
    for (int d = 0; d < 4; d++) begin
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk($sformatf("%s_digit%0d", tag, d), {20'h0, an, seg, dp}, {20'h0, e.an, e.seg, e.dp});
      end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic pulse(input logic n, input logic p);
    Next = n; Prev = p;
    @(negedge clk);
    Next = 1'b0; Prev = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Done = 1'b0; Next = 1'b0; Prev = 1'b0;
    Converted_1 = '0; Converted_2 = '0; Policy = '0; world = '0;
    randomize_cells();
    c1[0] = 4'h7; c2[0] = 4'h5; pol[0] = 2'b01; wld[0] = 2'b00;
    wld[5] = 2'b11; wld[3] = 2'b01;
    drive_inputs();
    repeat (3) @(negedge clk);

    chk("reset_an", 32'(an), 32'hF);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_dp", 32'(dp), 32'h1);
    chk("reset_idx", 32'(cell_idx), 32'h0);

    Reset = 1'b0;
    push_blank();
    check_display("blank");
    pulse(1'b1, 1'b0);
    chk("blank_next_ignored", 32'(cell_idx), 32'h0);

    Done = 1'b1;
    take_snapshot();
    push_cell(0, 1'b0);
    @(negedge clk);
    chk("show_idx", 32'(cell_idx), 32'h0);
    check_display("show0");

    for (int i = 1; i <= 12; i++) begin
      pulse(1'b1, 1'b0);
      chk($sformatf("next_idx%0d", i), 32'(cell_idx), 32'(i % 12));
      push_cell(i % 12, 1'b0);
      check_display($sformatf("cell%0d", i % 12));
    end

    pulse(1'b0, 1'b1);
    chk("prev_wrap", 32'(cell_idx), 32'd11);
    push_cell(11, 1'b0);
    check_display("cell11");

    repeat (5) pulse(1'b1, 1'b0);
    chk("idx4", 32'(cell_idx), 32'd4);
    pulse(1'b1, 1'b1);
    chk("both_hold", 32'(cell_idx), 32'd4);
    push_cell(4, 1'b0);
    check_display("both");

    Done = 1'b0;
    @(negedge clk);
    randomize_cells();
    drive_inputs();
    push_cell(4, 1'b1);
    check_display("stale");
    pulse(1'b1, 1'b0);
    chk("stale_next", 32'(cell_idx), 32'd5);

    Done = 1'b1; Next = 1'b1;
    take_snapshot();
    @(negedge clk);
    Next = 1'b0;
    chk("rise_wins", 32'(cell_idx), 32'h0);
    push_cell(0, 1'b0);
    check_display("reshow");

    #2 Reset = 1'b1;
    #1;
    chk("midreset_an", 32'(an), 32'hF);
    chk("midreset_seg", 32'(seg), 32'h7F);
    chk("midreset_dp", 32'(dp), 32'h1);
    chk("midreset_idx", 32'(cell_idx), 32'h0);
    Done = 1'b0;
    @(negedge clk);
    Reset = 1'b0;
    pulse(1'b1, 1'b0);
    chk("blank2_idx", 32'(cell_idx), 32'h0);
    push_blank();
    check_display("blank2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
